// File: rtl/ad_pkg.sv
// Shared types and default constants for the serial-ADC capture engine.
package ad_pkg;

    localparam int AD_W           = 16;
    localparam int SCLK_DIV_DEF   = 4;
    localparam int FRAME_BITS_DEF = 20;
    localparam int LEAD_BITS_DEF  = 4;
    localparam int CS_GAP_DEF     = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } ad_state_e;

    // cs_n is held low through setup, shifting and hold.
    function automatic logic cs_active(input ad_state_e s);
        return (s == S_SETUP) || (s == S_SHIFT) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/ad_spi_rx_if.sv
// ADC serial pins plus the sample output towards the downstream DSP.
interface ad_spi_rx_if;
    import ad_pkg::*;

    logic            cs_n;
    logic            sclk;
    logic            sdata;
    logic [AD_W-1:0] ad_data;
    logic            ad_vld;

    modport master (output cs_n, output sclk, output ad_data, output ad_vld, input sdata);
    modport slave  (input cs_n, input sclk, input ad_data, input ad_vld, output sdata);

endinterface

// File: rtl/ad_period_tmr.sv
// Sample-period timer on the 1 us tick, trigger generation and saturating overrun count.
module ad_period_tmr
    import ad_pkg::*;
(
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic        i_pluse_us,
    input  logic        i_en,
    input  logic [15:0] i_cfg_period,
    input  logic        i_ovr_clr,
    input  logic        i_busy,
    output logic        o_trig,
    output logic [7:0]  o_ovr_cnt
);

    logic [15:0] r_cnt;
    logic [7:0]  r_ovr;
    logic        w_run;
    logic        w_tc;

    assign w_run  = i_en && (i_cfg_period != 16'd0);
    assign w_tc   = (r_cnt == (i_cfg_period - 16'd1));
    assign o_trig = w_run && i_pluse_us && w_tc;

    // A period shrunk below the running count lets r_cnt roll through 16'hFFFF.
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (!w_run) begin
            r_cnt <= 16'd0;
        end else if (i_pluse_us) begin
            r_cnt <= w_tc ? 16'd0 : r_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_ovr <= 8'd0;
        end else if (i_ovr_clr) begin
            r_ovr <= 8'd0;
        end else if (o_trig && i_busy && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

    assign o_ovr_cnt = r_ovr;

endmodule

// File: rtl/ad_spi_rx.sv
// Serial-ADC frame engine: cs_n/sclk generation, MSB-first deserialiser, sample strobe.
// Optional AD_AVG4_EN: deliver the truncated mean of every four frames instead of each frame.
//
// state | meaning
// IDLE  | waiting for a period trigger
// SETUP | cs_n low, CS_GAP cycles before the first sclk fall
// SHIFT | FRAME_BITS sclk periods, low half then high half
// HOLD  | sclk high, cs_n low for CS_GAP cycles
// DONE  | one cycle, publish the captured word
module ad_spi_rx
    import ad_pkg::*;
#(
    parameter int SCLK_DIV   = SCLK_DIV_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int LEAD_BITS  = LEAD_BITS_DEF,
    parameter int CS_GAP     = CS_GAP_DEF
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic        i_pluse_us,
    input  logic        i_en,
    input  logic [15:0] i_cfg_period,
    input  logic        i_ovr_clr,
    output logic        o_busy,
    output logic [7:0]  o_ovr_cnt,
    ad_spi_rx_if.master bus
);

    localparam logic [7:0] DIV_M1   = 8'(SCLK_DIV - 1);
    localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);
    localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);
    localparam logic [5:0] DATA_LO  = 6'(LEAD_BITS);
    localparam logic [5:0] DATA_HI  = 6'(LEAD_BITS + AD_W);

    ad_state_e       r_state, w_state_nxt;
    logic [7:0]      r_tmr, w_tmr_nxt;
    logic [5:0]      r_bit, w_bit_nxt;
    logic            r_sclk, w_sclk_nxt;
    logic            r_cs_n;
    logic            r_sdata;
    logic            w_cap;
    logic            w_trig;
    logic            w_busy;
    logic [AD_W-1:0] r_shreg;
    logic [AD_W-1:0] r_ad_data;
    logic            r_ad_vld;

    assign w_busy = (r_state != S_IDLE);

    ad_period_tmr u_tmr (
        .i_clk_sys   (i_clk_sys),
        .i_rst_n     (i_rst_n),
        .i_pluse_us  (i_pluse_us),
        .i_en        (i_en),
        .i_cfg_period(i_cfg_period),
        .i_ovr_clr   (i_ovr_clr),
        .i_busy      (w_busy),
        .o_trig      (w_trig),
        .o_ovr_cnt   (o_ovr_cnt)
    );

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_tmr   <= 8'd0;
            r_bit   <= 6'd0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_sdata <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_bit   <= w_bit_nxt;
            r_sclk  <= w_sclk_nxt;
            r_cs_n  <= !cs_active(w_state_nxt);
            r_sdata <= bus.sdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_bit_nxt   = r_bit;
        w_sclk_nxt  = 1'b1;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_SETUP;
                    w_tmr_nxt   = GAP_M1;
                end
            end
            S_SETUP: begin
                if (r_tmr == 8'd0) begin
                    w_state_nxt = S_SHIFT;
                    w_tmr_nxt   = DIV_M1;
                    w_bit_nxt   = 6'd0;
                    w_sclk_nxt  = 1'b0;
                end else begin
                    w_tmr_nxt = r_tmr - 8'd1;
                end
            end
            S_SHIFT: begin
                w_sclk_nxt = r_sclk;
                if (r_tmr == 8'd0) begin
                    w_tmr_nxt = DIV_M1;
                    // Sample on the edge that raises sclk; the high half then ends the bit.
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                        w_cap      = 1'b1;
                    end else if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_HOLD;
                        w_tmr_nxt   = GAP_M1;
                    end else begin
                        w_bit_nxt  = r_bit + 6'd1;
                        w_sclk_nxt = 1'b0;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 8'd1;
                end
            end
            S_HOLD: begin
                if (r_tmr == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmr_nxt = r_tmr - 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
        end else if (w_cap && (r_bit >= DATA_LO) && (r_bit < DATA_HI)) begin
            r_shreg <= {r_shreg[AD_W-2:0], r_sdata};
        end
    end

`ifdef AD_AVG4_EN
    logic [AD_W+1:0] r_acc;
    logic [1:0]      r_fcnt;
    logic            r_en_d;
    logic [AD_W+1:0] w_sum;

    assign w_sum = r_acc + (AD_W+2)'(r_shreg);

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_fcnt    <= 2'd0;
            r_en_d    <= 1'b0;
            r_ad_data <= '0;
            r_ad_vld  <= 1'b0;
        end else begin
            r_en_d   <= i_en;
            r_ad_vld <= 1'b0;
            if (r_en_d && !i_en) begin
                r_acc  <= '0;
                r_fcnt <= 2'd0;
            end else if (r_state == S_DONE) begin
                if (r_fcnt == 2'd3) begin
                    r_ad_data <= w_sum[AD_W+1:2];
                    r_ad_vld  <= 1'b1;
                    r_acc     <= '0;
                    r_fcnt    <= 2'd0;
                end else begin
                    r_acc  <= w_sum;
                    r_fcnt <= r_fcnt + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            r_ad_data <= '0;
            r_ad_vld  <= 1'b0;
        end else begin
            r_ad_vld <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_ad_data <= r_shreg;
            end
        end
    end
`endif

    assign bus.cs_n    = r_cs_n;
    assign bus.sclk    = r_sclk;
    assign bus.ad_data = r_ad_data;
    assign bus.ad_vld  = r_ad_vld;
    assign o_busy      = w_busy;

endmodule

// File: doc/ad_spi_rx.md
Name: ad_spi_rx

Overview:
- Serial-ADC capture engine instantiated inside each ad_top channel (one per ch1..ch8).
- Generates cs_n/sclk frames at a programmed sample period.
- Deserialises sdata into a 16-bit sample and presents ad_data/ad_vld directly to the downstream dsp_top.
- Period, enable and overrun-clear come from ad_top's fx-bus register file.

Parameters:
SCLK_DIV, 4, sclk half-period in clk_sys cycles (legal range 2..255)
FRAME_BITS, 20, total sclk cycles per frame (legal range 17..32)
LEAD_BITS, 4, leading bits discarded before the 16-bit MSB-first data word (LEAD_BITS+16 <= FRAME_BITS)
CS_GAP, 3, clk_sys cycles of cs_n-low setup before the first sclk fall, and of hold after the last rise

Ports:
clk_sys  in  1  system clock
rst_n  in  1  synchronous active-low reset
pluse_us  in  1  one-cycle pulse every 1 us
en  in  1  conversion enable
cfg_period  in  16  sample period in us; 0 = no triggers
ovr_clr  in  1  one-cycle pulse, clears ovr_cnt
cs_n  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idles high
sdata  in  1  ADC serial data
ad_data  out  16  last captured sample, raw ADC code
ad_vld  out  1  one-cycle strobe, ad_data new
busy  out  1  frame in progress (state != IDLE)
ovr_cnt  out  8  saturating count of dropped triggers

Behaviour:
- Clock and reset: one clock, clk_sys. Reset rst_n is synchronous and active-low.
- Reset values: cs_n=1, sclk=1, ad_data=0, ad_vld=0, busy=0, ovr_cnt=0; period timer=0; FSM=IDLE.
- Reset asserted mid-frame: all of the above apply on the next clk_sys edge. No ad_vld is issued for the aborted frame.
- Period timer:
  - Counts pluse_us while en=1 and cfg_period!=0.
  - When the count reaches cfg_period-1 and pluse_us=1: timer wraps to 0 and a one-cycle trigger is issued.
  - en=0 or cfg_period=0: timer is held at 0.
  - cfg_period written smaller than the current count: timer wraps at 16'hFFFF. Software must toggle en when changing cfg_period.
- Trigger while busy=1: trigger is dropped and ovr_cnt increments, saturating at 255.
  - ovr_clr zeroes ovr_cnt.
  - ovr_clr and an increment in the same cycle: ovr_clr wins and the result is 0.
- sdata input: registered once (sdata_r) before use.
- FSM states:
  - IDLE: on trigger, go to SETUP; cs_n goes 0 on the next edge.
  - SETUP: wait CS_GAP cycles, then go to SHIFT.
  - SHIFT:
    - Runs FRAME_BITS bit periods of 2*SCLK_DIV cycles each.
    - Each bit period: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
    - The bit is captured from sdata_r on the clk_sys cycle in which sclk goes 0->1.
    - Bit index b = 0..FRAME_BITS-1. Bits with LEAD_BITS <= b < LEAD_BITS+16 shift into a 16-bit register MSB first. All other bits are ignored.
    - After the high half of the last bit, go to HOLD.
  - HOLD: sclk=1, cs_n=0 for CS_GAP cycles, then cs_n=1. Go to DONE.
  - DONE (one cycle): ad_data <= shift register, ad_vld=1, then go to IDLE.
- Latency: trigger to ad_vld = 1 + CS_GAP + FRAME_BITS*2*SCLK_DIV + CS_GAP + 1 cycles. With defaults this is 168 clk_sys cycles.
- Throughput: a trigger arriving in the DONE cycle counts as overrun. A trigger arriving while in IDLE starts a frame.
- en deasserted mid-frame: the current frame completes and delivers ad_vld. No new triggers follow.
- ad_data holds its value between strobes.

Optional Feature:
- Macro: AD_AVG4_EN.
- Defined:
  - Four consecutive frames are summed in an 18-bit accumulator.
  - On every 4th DONE: ad_data <= sum[17:2] (truncating), ad_vld pulses, and the accumulator and frame counter clear.
  - DONE cycles 1-3 produce no ad_vld.
  - en falling clears the accumulator and frame counter.
- Undefined: every frame produces ad_vld, as described above.

Decomposition:
- Package ad_pkg:
  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD, DONE, 3 bits).
  - Default constants for SCLK_DIV, FRAME_BITS, LEAD_BITS, CS_GAP.
  - AD_W=16.
- One sub-module: ad_period_tmr (pluse_us counter, trigger generation, overrun counter).
- The FSM, sclk divider and shifter stay in ad_spi_rx.

Test Plan:
- Defaults, cfg_period=10, en=1, ADC model drives 4'b0000 then 16'hA5C3 then 0s -> ad_data=16'hA5C3 with a single ad_vld 168 cycles after the trigger; sclk shows exactly 20 low pulses; cs_n is high between frames.
- cfg_period=1 (1 us trigger), SCLK_DIV=4 -> frame is longer than the period; ovr_cnt increments once per dropped trigger; ovr_clr issued in the same cycle as an increment gives ovr_cnt=0; force 300 drops -> ovr_cnt=255.
- rst_n=0 pulsed mid-SHIFT (bit 9) -> next edge gives cs_n=1, sclk=1, busy=0, ad_data=0, no ad_vld; the next trigger captures a correct fresh frame.
- en dropped during SHIFT -> the frame completes and ad_vld is issued with the correct data; no further cs_n activity for 50 us.
- cfg_period=0 with en=1 -> no cs_n activity for 100 us; then cfg_period=5 -> frames start every 5 us ±1 cycle.
- AD_AVG4_EN defined, frames 16'h0004, 16'h0008, 16'h000C, 16'h0011 -> one ad_vld with ad_data=16'h000A (sum 41, >>2); no ad_vld on frames 1-3.
